// File: rtl/tpu_sequencer.sv
// Instruction sequencer for the TPU datapath: decodes host instructions and drives
// load/store bursts to the unified buffer and matmul control to the systolic array.
module tpu_sequencer #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               mem_ready,
  input  logic               mm_done,
  output logic               load,
  output logic               store,
  output logic               matmul,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               beat_last,
  output logic               busy,
  output logic               done,
  output logic               illegal
);

  localparam int LEN_W = INSTR_W - 3 - ADDR_W;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_STORE  = 3'b010;
  localparam logic [2:0] OP_MATMUL = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE,
    ST_MATMUL
  } state_t;

  state_t             state;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   beat;

  logic [2:0]         op_field;
  logic [ADDR_W-1:0]  base_field;
  logic [LEN_W-1:0]   len_field;

  assign op_field   = instr[INSTR_W-1 -: 3];
  assign base_field = instr[INSTR_W-4 -: ADDR_W];
  assign len_field  = instr[LEN_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      len         <= '0;
      beat        <= '0;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      load        <= 1'b0;
      store       <= 1'b0;
      matmul      <= 1'b0;
      mem_addr    <= '0;
      beat_last   <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            case (op_field)
              OP_NOP: ;
              OP_LOAD, OP_STORE: begin
                len         <= len_field;
                beat        <= '0;
                mem_addr    <= base_field;
                beat_last   <= (len_field == '0);
                load        <= (op_field == OP_LOAD);
                store       <= (op_field == OP_STORE);
                instr_ready <= 1'b0;
                busy        <= 1'b1;
                state       <= (op_field == OP_LOAD) ? ST_LOAD : ST_STORE;
              end
              OP_MATMUL: begin
                matmul      <= 1'b1;
                instr_ready <= 1'b0;
                busy        <= 1'b1;
                state       <= ST_MATMUL;
              end
              default: illegal <= 1'b1;
            endcase
          end
        end
        ST_LOAD, ST_STORE: begin
          // mem_addr tracks base+beat incrementally, so wrap falls out of the adder width
          if (mem_ready) begin
            if (beat == len) begin
              load        <= 1'b0;
              store       <= 1'b0;
              beat_last   <= 1'b0;
              done        <= 1'b1;
              instr_ready <= 1'b1;
              busy        <= 1'b0;
              state       <= ST_IDLE;
            end else begin
              beat      <= beat + LEN_W'(1);
              mem_addr  <= mem_addr + ADDR_W'(1);
              beat_last <= ((beat + LEN_W'(1)) == len);
            end
          end
        end
        ST_MATMUL: begin
          if (mm_done) begin
            matmul      <= 1'b0;
            done        <= 1'b1;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_sequencer.sv
// Scoreboard bench for tpu_sequencer: instructions expand into expected beat/done/illegal
// events; a negedge monitor pops and compares each event the DUT presents.
module tb_tpu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mm_done = 1'b0;
  logic        instr_ready, load, store, matmul, beat_last, busy, done, illegal;
  logic [7:0]  mem_addr;

  tpu_sequencer #(.INSTR_W(16), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .mem_ready(mem_ready), .mm_done(mm_done),
    .load(load), .store(store), .matmul(matmul), .mem_addr(mem_addr),
    .beat_last(beat_last), .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // kinds: 1 load beat, 2 store beat, 3 matmul completion sample, 4 done, 5 illegal
  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] addr;
    logic       last;
  } ev_t;

  ev_t expq[$];
  bit  mr_q[$];
  bit  mm_q[$];
  bit  rnd_mode = 1'b0;
  int  total = 0;
  int  bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic observe(input ev_t ev);
    ev_t e;
    total++;
    if (expq.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got %0h expected none at %0t", ev, $time);
    end else begin
      e = expq.pop_front();
      if (ev !== e) begin
        bad++;
        $display("FAIL event: got %0h expected %0h at %0t", ev, e, $time);
      end
    end
  endtask

  // Reference: an instruction is the list of events it must produce, in order
  task automatic expand(input logic [15:0] ins);
    logic [2:0] op;
    logic [7:0] b;
    int         l;
    op = ins[15:13];
    b  = ins[12:5];
    l  = int'(ins[4:0]);
    case (op)
      3'd0: ;
      3'd1, 3'd2: begin
        for (int i = 0; i <= l; i++)
          expq.push_back(ev_t'{kind: op, addr: 8'(int'(b) + i), last: (i == l)});
        expq.push_back(ev_t'{kind: 3'd4, addr: 8'h00, last: 1'b0});
      end
      3'd3: begin
        expq.push_back(ev_t'{kind: 3'd3, addr: 8'h00, last: 1'b0});
        expq.push_back(ev_t'{kind: 3'd4, addr: 8'h00, last: 1'b0});
      end
      default: expq.push_back(ev_t'{kind: 3'd5, addr: 8'h00, last: 1'b0});
    endcase
  endtask

  // Memory/array responses change at posedge+2 so scripts pushed at posedge+1 apply next cycle
  initial forever begin
    @(posedge clk);
    #2;
    if (mr_q.size() > 0)   mem_ready = mr_q.pop_front();
    else if (rnd_mode)     mem_ready = ($urandom_range(3) != 0);
    else                   mem_ready = 1'b1;
    if (mm_q.size() > 0)   mm_done = mm_q.pop_front();
    else if (rnd_mode)     mm_done = ($urandom_range(5) == 0);
    else                   mm_done = 1'b0;
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("strobe_onehot", 32'($countones({load, store, matmul}) <= 1), 32'd1);
      chk("busy_vs_ready", busy, !instr_ready);
      chk("done_and_illegal", done & illegal, 1'b0);
      if ((load || store) && mem_ready)
        observe(ev_t'{kind: load ? 3'd1 : 3'd2, addr: mem_addr, last: beat_last});
      if (matmul && mm_done) observe(ev_t'{kind: 3'd3, addr: 8'h00, last: 1'b0});
      if (done)    observe(ev_t'{kind: 3'd4, addr: 8'h00, last: 1'b0});
      if (illegal) observe(ev_t'{kind: 3'd5, addr: 8'h00, last: 1'b0});
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 400) begin
      @(posedge clk); #1; n++;
    end
    if (!instr_ready) chk("ready_timeout", instr_ready, 1'b1);
  endtask

  // Returns at posedge+1 of the cycle after the accepting edge
  task automatic send(input logic [15:0] ins);
    wait_ready();
    instr = ins;
    instr_valid = 1'b1;
    expand(ins);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = 16'($urandom);
  endtask

  task automatic latency(output int k);
    k = 1;
    while (!done && k < 100) begin
      @(posedge clk); #1; k++;
    end
  endtask

  task automatic drain();
    @(posedge clk); #1;
    chk("queue_empty", 32'(expq.size()), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, instr_ready, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_strobes"}, {load, store, matmul}, 3'b000);
    chk({tag, "_pulses"}, {done, illegal}, 2'b00);
    chk({tag, "_last"}, beat_last, 1'b0);
    chk({tag, "_addr"}, mem_addr, 8'h00);
  endtask

  initial begin
    int k;
    logic [2:0] op;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // LOAD base 0x10 len 3, memory always ready
    send({3'b001, 8'h10, 5'd3});
    chk("load_first_addr", mem_addr, 8'h10);
    latency(k);
    chk("load_latency", k, 5);
    drain();

    // STORE base 0xFE len 3 with a two-cycle stall on the second beat
    send({3'b010, 8'hFE, 5'd3});
    mr_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    latency(k);
    chk("store_latency", k, 7);
    drain();

    // MATMUL finishing 7 cycles later, then a spurious mm_done while idle
    send({3'b011, 13'h0});
    mm_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    latency(k);
    chk("matmul_latency", k, 8);
    drain();
    repeat (4) begin
      @(posedge clk); #1;
      chk("spurious_mm_ignored", {matmul, instr_ready}, 2'b01);
    end

    // Illegal opcode then NOP
    send({3'b101, 13'h1ABC});
    chk("illegal_pulse", illegal, 1'b1);
    send(16'h0000);
    chk("illegal_once", illegal, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("nop_idle", {instr_ready, load, store, matmul, done}, 5'b10000);
    end
    drain();

    // Back-to-back LOAD len 0 then STORE len 0 with valid held high
    instr = {3'b001, 8'h20, 5'd0};
    instr_valid = 1'b1;
    expand(instr);
    @(posedge clk); #1;
    instr = {3'b010, 8'h30, 5'd0};
    expand(instr);
    chk("b2b_load", {load, instr_ready}, 2'b10);
    @(posedge clk); #1;
    chk("b2b_done_ready", {done, instr_ready}, 2'b11);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("b2b_store", {store, mem_addr}, {1'b1, 8'h30});
    latency(k);
    chk("b2b_store_latency", k, 2);
    drain();

    // Reset during LOAD at beat 2
    send({3'b001, 8'h40, 5'd7});
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_addr", mem_addr, 8'h42);
    #2 rst = 1'b1;
    #1 chk_reset_vals("abort");
    expq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_idle", {instr_ready, busy, done}, 3'b100);

    // Randomized instruction stream against the reference expansion
    rnd_mode = 1'b1;
    repeat (80) begin
      repeat ($urandom_range(2)) begin
        @(posedge clk); #1;
      end
      k = int'($urandom_range(9));
      op = (k < 4) ? 3'd1 : (k < 7) ? 3'd2 : (k == 7) ? 3'd3 : 3'($urandom_range(7));
      send({op, 8'($urandom), 5'($urandom_range(31))});
    end
    wait_ready();
    rnd_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("final_queue_empty", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
